// File: rtl/block_stream_feeder.sv
// -----------------------------------------------------------------------------
// block_stream_feeder
//
// Purpose:
//   Buffers one block of TOTAL_SAMPLES samples from a valid/ready source, then
//   replays the block twice as a framed stream: pass 0 feeds the mean
//   calculator (start_mean ... mean_done), pass 1 feeds the variance unit
//   (start_var ... var_done). A block_done pulse closes each block.
//
// Optional feature (macro BLOCK_STREAM_FEEDER_TIMEOUT_EN):
//   When defined, each WAIT state gives up after TIMEOUT_CYCLES cycles without
//   the matching done pulse: err is set, block_done pulses, and the block is
//   dropped. When undefined, WAIT states wait indefinitely.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   in_data/in_valid upstream sample and its valid
//   in_ready         high only while filling the buffer
//   out_data         replayed sample, forced to 0 whenever out_valid is low
//   out_valid        out_data valid (TOTAL_SAMPLES consecutive cycles per pass)
//   start_mean       one-cycle pulse opening the mean pass
//   start_var        one-cycle pulse opening the variance pass
//   mean_done        done pulse from the mean calculator
//   var_done         done pulse from the variance unit
//   pass_id          0 during the mean pass, 1 during the variance pass
//   block_done       one-cycle pulse after the block is finished (or dropped)
//   err              sticky protocol error, cleared only by reset
// -----------------------------------------------------------------------------
module block_stream_feeder #(
  parameter int DATA_WIDTH     = 8,
  parameter int TOTAL_SAMPLES  = 64,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic                  start_mean,
  output logic                  start_var,
  input  logic                  mean_done,
  input  logic                  var_done,
  output logic                  pass_id,
  output logic                  block_done,
  output logic                  err
);

  localparam int              PTR_W    = $clog2(TOTAL_SAMPLES);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(TOTAL_SAMPLES - 1);

  // Elaboration-time sanity check on the configuration.
  if (TOTAL_SAMPLES < 2 || (TOTAL_SAMPLES & (TOTAL_SAMPLES - 1)) != 0 ||
      TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("block_stream_feeder: TOTAL_SAMPLES must be a power of 2 >= 2 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [2:0] {
    FILL        = 3'd0,
    MEAN_START  = 3'd1,
    MEAN_STREAM = 3'd2,
    MEAN_WAIT   = 3'd3,
    VAR_START   = 3'd4,
    VAR_STREAM  = 3'd5,
    VAR_WAIT    = 3'd6,
    DONE        = 3'd7
  } state_t;

  state_t                state_reg;
  logic [PTR_W-1:0]      wr_ptr_reg;
  logic [PTR_W-1:0]      rd_ptr_reg;
  logic [DATA_WIDTH-1:0] mem [TOTAL_SAMPLES];

  logic                  in_ready_reg;
  logic [DATA_WIDTH-1:0] out_data_reg;
  logic                  out_valid_reg;
  logic                  start_mean_reg;
  logic                  start_var_reg;
  logic                  pass_id_reg;
  logic                  block_done_reg;
  logic                  err_reg;

  logic write_en;
  logic stray_done;
  logic wait_timeout;

  assign write_en = (state_reg == FILL) && in_ready_reg && in_valid;

  // A done pulse outside its own WAIT state is a protocol violation.
  assign stray_done = (mean_done && (state_reg != MEAN_WAIT)) ||
                      (var_done  && (state_reg != VAR_WAIT));

`ifdef BLOCK_STREAM_FEEDER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] to_cnt_reg;

  // Counter is held at 0 outside the WAIT states, so it restarts on every
  // WAIT entry. Hitting TIMEOUT_CYCLES-1 here means the edge that follows is
  // the TIMEOUT_CYCLES-th WAIT cycle without a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_reg <= '0;
    end else if (state_reg == MEAN_WAIT || state_reg == VAR_WAIT) begin
      to_cnt_reg <= to_cnt_reg + TO_W'(1);
    end else begin
      to_cnt_reg <= '0;
    end
  end

  assign wait_timeout = (to_cnt_reg == TO_W'(TIMEOUT_CYCLES - 1)) &&
                        (((state_reg == MEAN_WAIT) && !mean_done) ||
                         ((state_reg == VAR_WAIT)  && !var_done));
`else
  assign wait_timeout = 1'b0;
`endif

  // Sample buffer: write-only during FILL, contents need no reset.
  always_ff @(posedge clk) begin
    if (write_en) begin
      mem[wr_ptr_reg] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_reg <= 1'b0;
    end else if (stray_done || wait_timeout) begin
      err_reg <= 1'b1;
    end
  end

  // Main sequencer. Outputs are registered and describe the state being
  // entered, so each output is valid for exactly the cycles spent in it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= FILL;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      in_ready_reg   <= 1'b0;
      out_data_reg   <= '0;
      out_valid_reg  <= 1'b0;
      start_mean_reg <= 1'b0;
      start_var_reg  <= 1'b0;
      pass_id_reg    <= 1'b0;
      block_done_reg <= 1'b0;
    end else begin
      start_mean_reg <= 1'b0;
      start_var_reg  <= 1'b0;
      block_done_reg <= 1'b0;

      case (state_reg)
        FILL: begin
          in_ready_reg <= 1'b1;
          if (write_en) begin
            // Pointer wraps to 0 on the last write, leaving it cleared.
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (wr_ptr_reg == LAST_IDX) begin
              state_reg      <= MEAN_START;
              in_ready_reg   <= 1'b0;
              start_mean_reg <= 1'b1;
              pass_id_reg    <= 1'b0;
            end
          end
        end

        MEAN_START, VAR_START: begin
          out_valid_reg <= 1'b1;
          out_data_reg  <= mem[rd_ptr_reg];
          state_reg     <= (state_reg == MEAN_START) ? MEAN_STREAM : VAR_STREAM;
        end

        // rd_ptr_reg holds the index of the sample currently on out_data.
        MEAN_STREAM, VAR_STREAM: begin
          if (rd_ptr_reg == LAST_IDX) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            rd_ptr_reg    <= '0;
            state_reg     <= (state_reg == MEAN_STREAM) ? MEAN_WAIT : VAR_WAIT;
          end else begin
            rd_ptr_reg   <= rd_ptr_reg + PTR_W'(1);
            out_data_reg <= mem[rd_ptr_reg + PTR_W'(1)];
          end
        end

        MEAN_WAIT: begin
          if (mean_done) begin
            state_reg     <= VAR_START;
            start_var_reg <= 1'b1;
            pass_id_reg   <= 1'b1;
          end else if (wait_timeout) begin
            state_reg      <= DONE;
            block_done_reg <= 1'b1;
            pass_id_reg    <= 1'b0;
          end
        end

        VAR_WAIT: begin
          if (var_done || wait_timeout) begin
            state_reg      <= DONE;
            block_done_reg <= 1'b1;
            pass_id_reg    <= 1'b0;
          end
        end

        DONE: begin
          state_reg    <= FILL;
          in_ready_reg <= 1'b1;
        end

        default: begin
          state_reg <= FILL;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_reg;
  assign out_data   = out_data_reg;
  assign out_valid  = out_valid_reg;
  assign start_mean = start_mean_reg;
  assign start_var  = start_var_reg;
  assign pass_id    = pass_id_reg;
  assign block_done = block_done_reg;
  assign err        = err_reg;

endmodule

// File: tb/tb_block_stream_feeder.sv
// -----------------------------------------------------------------------------
// tb_block_stream_feeder
//
// Directed sequence of block transactions with random sample data. The
// reference model is the block itself: whatever was accepted upstream must
// come back twice, in order, framed by the start pulses; err follows the
// protocol rules (set by a stray done pulse or a timeout, cleared by reset).
// Build with +define+BLOCK_STREAM_FEEDER_TIMEOUT_EN to exercise the timeout.
// -----------------------------------------------------------------------------
module tb_block_stream_feeder;

  localparam int DW = 8;
  localparam int N  = 64;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          start_mean;
  logic          start_var;
  logic          mean_done;
  logic          var_done;
  logic          pass_id;
  logic          block_done;
  logic          err;

  always #5 clk = ~clk;

  block_stream_feeder #(
    .DATA_WIDTH    (DW),
    .TOTAL_SAMPLES (N),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .start_mean(start_mean),
    .start_var (start_var),
    .mean_done (mean_done),
    .var_done  (var_done),
    .pass_id   (pass_id),
    .block_done(block_done),
    .err       (err)
  );

  int            checks   = 0;
  int            failures = 0;
  int            inv_bad  = 0;
  bit            busy     = 1'b0;
  bit            err_exp  = 1'b0;
  logic [DW-1:0] blk [N];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock, then sample outputs 1 time unit after the edge and track the
  // always-true framing rules.
  task automatic step();
    @(posedge clk);
    #1;
    if (start_mean && start_var)                inv_bad++;
    if ((start_mean || start_var) && out_valid) inv_bad++;
    if (!out_valid && out_data !== '0)          inv_bad++;
    if (busy && in_ready)                       inv_bad++;
  endtask

  // Offer a fresh block upstream until N samples are accepted.
  task automatic fill_block(input bit seq, input bit toggle, input bit hold_valid);
    int k = 0;
    int cyc = 0;
    bit ph = 1'b0;
    bit accept;
    for (int i = 0; i < N; i++) blk[i] = seq ? DW'(i) : DW'($urandom);
    while (k < N && cyc < 4 * N + 8) begin
      ph       = toggle ? ~ph : 1'b1;
      in_valid = ph;
      in_data  = ph ? blk[k] : DW'($urandom);
      accept   = in_valid && in_ready;
      step();
      cyc++;
      if (accept) k++;
    end
    chk("fill_accepted", k, N);
    busy     = 1'b1;
    in_valid = hold_valid;
    in_data  = DW'($urandom);
    $display("fill block: %0d samples in %0d cycles (toggle=%0d)", k, cyc, toggle);
  endtask

  // Expects the start pulse of pass p on the current cycle; checks the whole
  // stream and stops on the first WAIT cycle. stray_at drives the other
  // pass's done pulse on that sample.
  task automatic stream_pass(input bit p, input int stray_at);
    int bad = 0;
    chk(p ? "start_var" : "start_mean", p ? start_var : start_mean, 1);
    chk("start_other_low", p ? start_mean : start_var, 0);
    chk("start_no_valid", out_valid, 0);
    chk("start_pass_id", pass_id, p);
    for (int i = 0; i < N; i++) begin
      if (i == stray_at) begin
        if (p) mean_done = 1'b1; else var_done = 1'b1;
        err_exp = 1'b1;
      end
      step();
      mean_done = 1'b0;
      var_done  = 1'b0;
      if (out_valid !== 1'b1) bad++;
      chk($sformatf("p%0d_sample_%0d", p, i), out_data, blk[i]);
      if (i == N / 2) chk("stream_pass_id", pass_id, p);
    end
    chk("stream_valid_run", bad, 0);
    step();
    chk("wait_idle_bus", {out_valid, out_data}, 0);
    chk("err_after_stream", err, err_exp);
    $display("pass %0d streamed %0d samples", p, N);
  endtask

  // Waits done_wait idle WAIT cycles, then delivers the matching done pulse.
  task automatic give_done(input bit p, input int done_wait);
    int early = 0;
    for (int d = 0; d < done_wait; d++) begin
      step();
      if (start_var || start_mean || block_done || out_valid) early++;
    end
    chk("wait_holds", early, 0);
    if (p) var_done = 1'b1; else mean_done = 1'b1;
    step();
    mean_done = 1'b0;
    var_done  = 1'b0;
    $display("pass %0d done after %0d wait cycles", p, done_wait);
  endtask

  task automatic finish_block();
    chk("block_done_pulse", block_done, 1);
    chk("done_in_ready_low", in_ready, 0);
    busy = 1'b0;
    step();
    in_valid = 1'b0;
    chk("block_done_single", block_done, 0);
    chk("in_ready_after_done", in_ready, 1);
    chk("err_block_end", err, err_exp);
    chk("invariants", inv_bad, 0);
    $display("block complete err=%0d", err);
  endtask

  task automatic full_block(input bit seq, input bit toggle, input int mw, input int vw,
                            input int stray_at);
    fill_block(seq, toggle, toggle);
    stream_pass(1'b0, stray_at);
    give_done(1'b0, mw);
    stream_pass(1'b1, -1);
    give_done(1'b1, vw);
    finish_block();
  endtask

  initial begin
    rst_n     = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;
    mean_done = 1'b0;
    var_done  = 1'b0;
    #1;
    chk("reset_outputs",
        {in_ready, out_valid, start_mean, start_var, pass_id, block_done, err, out_data}, 0);
    step();
    step();
    rst_n = 1'b1;
    chk("in_ready_at_release", in_ready, 0);
    step();
    chk("in_ready_first_clock", in_ready, 1);
    $display("reset released");

    // Sequential data, continuous valid, done pulses 5 and 3 cycles late.
    full_block(1'b1, 1'b0, 5, 3, -1);

    // Toggling valid, upstream keeps pushing during the replay.
    full_block(1'b0, 1'b1, 2, 2, -1);

    // Done on the very first WAIT cycle of each pass.
    full_block(1'b0, 1'b0, 0, 0, -1);

    // Stray var_done in the middle of the mean stream.
    full_block(1'b0, 1'b0, 6, 1, 10);

    // Reset in the middle of the mean stream at sample 30.
    fill_block(1'b0, 1'b0, 1'b0);
    chk("rst_test_start_mean", start_mean, 1);
    for (int i = 0; i <= 30; i++) begin
      step();
      chk($sformatf("pre_rst_sample_%0d", i), out_data, blk[i]);
    end
    #1;
    rst_n   = 1'b0;
    busy    = 1'b0;
    err_exp = 1'b0;
    #1;
    chk("rst_out_valid_now", out_valid, 0);
    chk("rst_err_cleared", err, 0);
    step();
    chk("rst_in_ready_low", in_ready, 0);
    rst_n = 1'b1;
    step();
    chk("rst_in_ready_next", in_ready, 1);
    $display("mid-stream reset applied");
    full_block(1'b0, 1'b0, 1, 1, -1);

    // Withheld var_done.
    fill_block(1'b0, 1'b0, 1'b0);
    stream_pass(1'b0, -1);
    give_done(1'b0, 2);
    stream_pass(1'b1, -1);
`ifdef BLOCK_STREAM_FEEDER_TIMEOUT_EN
    begin
      int early = 0;
      for (int c = 1; c < TO; c++) begin
        step();
        if (block_done || start_mean || start_var) early++;
      end
      chk("timeout_not_early", early, 0);
      step();
      err_exp = 1'b1;
      finish_block();
      $display("timeout after %0d wait cycles", TO);
    end
`else
    begin
      int early = 0;
      for (int c = 0; c < 3 * TO; c++) begin
        step();
        if (block_done || start_mean || start_var) early++;
      end
      chk("wait_indefinite", early, 0);
      give_done(1'b1, 0);
      finish_block();
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/block_stream_feeder.md
Name: block_stream_feeder

Overview:
- Front-end sequencer that buffers one block of TOTAL_SAMPLES samples from an upstream valid/ready source.
- Replays the buffered block twice as a framed stream: first pass to the mean calculator, second pass to the variance unit.
- Each pass is framed by a one-cycle start pulse and closed by the consumer's done pulse.
- Sits between the pixel/sample source and the mean/variance statistics pipeline, acting as the transmitter side of their start/stream/ready protocol.

Parameters:
- DATA_WIDTH, 8, width of each sample.
- TOTAL_SAMPLES, 64, samples per block; must be a power of 2, at least 2.
- TIMEOUT_CYCLES, 1024, maximum wait for a done pulse. Used only with the optional feature.

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, reset: asynchronous, active-low.
- in_data, input, DATA_WIDTH, upstream sample.
- in_valid, input, 1, upstream sample valid.
- in_ready, output, 1, feeder accepts a sample this cycle.
- out_data, output, DATA_WIDTH, replayed sample to the statistics units.
- out_valid, output, 1, out_data valid.
- start_mean, output, 1, one-cycle pulse opening pass 1.
- start_var, output, 1, one-cycle pulse opening pass 2.
- mean_done, input, 1, pulse from the mean calculator when its result is ready.
- var_done, input, 1, pulse from the variance unit when its result is ready.
- pass_id, output, 1, 0 during the mean pass, 1 during the variance pass.
- block_done, output, 1, one-cycle pulse after the variance pass completes.
- err, output, 1, sticky protocol error flag; cleared only by reset.

Behaviour:
- Reset values: all outputs 0, state FILL, write/read pointers 0, err 0. in_ready becomes 1 on the first clock after reset release.
- Storage is TOTAL_SAMPLES x DATA_WIDTH registers. Pointers are $clog2(TOTAL_SAMPLES) bits wide and never wrap inside a pass.
- States: FILL, MEAN_START, MEAN_STREAM, MEAN_WAIT, VAR_START, VAR_STREAM, VAR_WAIT, DONE.
- FILL:
  - in_ready=1.
  - On in_valid&&in_ready, write buf[wr_ptr] and increment wr_ptr.
  - On the write with wr_ptr==TOTAL_SAMPLES-1, go to MEAN_START and clear wr_ptr.
  - in_ready=0 in every other state; upstream back-pressure is absolute.
- MEAN_START: start_mean=1 for exactly one cycle, out_valid=0, pass_id=0; go to MEAN_STREAM.
- MEAN_STREAM:
  - out_valid=1, out_data=buf[rd_ptr] (registered outputs), rd_ptr increments each cycle.
  - out_valid is high for exactly TOTAL_SAMPLES consecutive cycles, with samples in write order.
  - First valid sample appears the cycle after the start pulse.
  - After the last sample go to MEAN_WAIT and clear rd_ptr.
- MEAN_WAIT: out_valid=0, out_data=0; on mean_done go to VAR_START.
- VAR_START, VAR_STREAM, VAR_WAIT: identical to the mean pass, but use start_var and var_done, with pass_id=1.
- DONE: block_done=1 for one cycle; return to FILL.
- Done pulses are honoured only in the matching WAIT state. Any mean_done or var_done arriving in another state is ignored and sets err=1; state is unaffected.
- Done arriving in the same cycle the WAIT state is entered is honoured. The next state is evaluated from the registered state.
- start_mean and start_var are never high together. Neither start pulse is ever coincident with out_valid.
- Reset mid-operation: the buffer contents become don't-care, the partial block is discarded, and the FSM returns to FILL with empty pointers.
- out_data is 0 whenever out_valid=0, so a downstream accumulator sampling an idle bus adds nothing.
- Latency:
  - Last accepted input to start_mean: 1 cycle.
  - Full block in to block_done: TOTAL_SAMPLES fill cycles + 2*(TOTAL_SAMPLES+1) stream cycles + the two consumer waits + 1.

Optional Feature:
- Macro: BLOCK_STREAM_FEEDER_TIMEOUT_EN.
- When defined:
  - A cycle counter runs in MEAN_WAIT and VAR_WAIT.
  - If the counter reaches TIMEOUT_CYCLES with no done pulse, set err=1, pulse block_done, and return to FILL, dropping the block.
  - The counter clears on every WAIT entry.
- When undefined: no counter exists, WAIT states wait indefinitely, and TIMEOUT_CYCLES is unused.

Test Plan:
- Fill 64 samples 0..63 with in_valid held high; mean_done 5 cycles after the stream ends; var_done 3 cycles after its stream ends. Required response: start_mean one cycle, then out_data 0..63 on 64 consecutive valid cycles; start_var, then 0..63 again; block_done once; err=0.
- Fill with in_valid toggling every other cycle. Required response: exactly 64 writes, correct order on replay, and in_ready=0 from MEAN_START until the cycle after block_done.
- Pulse var_done during MEAN_STREAM. Required response: err=1, streaming continues unchanged, FSM still waits in MEAN_WAIT for mean_done.
- Assert rst_n low at stream sample 30, then release. Required response: out_valid=0 immediately, in_ready=1 next clock, a new block of 64 accepted, and replay contains only new data.
- mean_done in the same cycle MEAN_WAIT is entered. Required response: start_var pulses on the next cycle.
- With BLOCK_STREAM_FEEDER_TIMEOUT_EN and TIMEOUT_CYCLES=16, withhold var_done. Required response: err=1 and block_done 16 cycles into VAR_WAIT, then in_ready=1.
